silencer: RTL

Per-transducer slew-rate limiter directly downstream of the modulation stage. On every `OUT_VALID` pulse from modulation it snapshots the modulated duty array `DUTY_M`. It then walks the array one transducer per clock, moving each output duty toward its new target by at most `STEP`. When a full sweep finishes, it presents the result to the PWM generator with a one-cycle valid pulse. This suppresses audible noise from abrupt duty changes.

---
 rtl/silencer_pkg.sv | 13 +
 rtl/silencer_step.sv | 34 +++
 rtl/silencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/silencer_pkg.sv
// Shared types and sizing constants for the per-transducer slew-rate limiter.
package silencer_pkg;

    localparam int WIDTH_DEF = 13;
    localparam int DEPTH_DEF = 249;
    localparam int IDX_W     = $clog2(DEPTH_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } silencer_state_t;

endpackage

// File: rtl/silencer_step.sv
// Single-element slew step: move cur toward tgt by at most step, or snap when disabled.
module silencer_step
    import silencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0] step,
    input  logic             enable,
    output logic [WIDTH-1:0] nxt
);

    function automatic logic signed [WIDTH:0] abs_diff(input logic signed [WIDTH:0] v);
        return (v < 0) ? -v : v;
    endfunction

    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] mag;
    logic signed [WIDTH:0] step_s;

    // One extra bit keeps the difference of two unsigned duties exact.
    assign diff   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    assign mag    = abs_diff(diff);
    assign step_s = $signed({1'b0, step});

    always_comb begin
        nxt = tgt;
        if (enable && (mag > step_s)) begin
            nxt = diff[WIDTH] ? (cur - step) : (cur + step);
        end
    end

endmodule

// File: rtl/silencer.sv
// Sweeps the duty array one transducer per clock, slew-limiting each toward its snapshot target.
module silencer
    import silencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] duty_m [0:DEPTH-1],
    input  logic             in_valid,
    output logic [WIDTH-1:0] duty_s [0:DEPTH-1],
    output logic             out_valid
);

    localparam int             IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    silencer_state_t state, state_nxt;

    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] tgt [0:DEPTH-1];
    logic [WIDTH-1:0] pnd [0:DEPTH-1];
    logic [WIDTH-1:0] cur [0:DEPTH-1];
    logic             pend;

    logic start, reload, proc, last, pnd_load;
    logic [WIDTH-1:0] nxt;

    silencer_step #(.WIDTH(WIDTH)) u_step (
        .cur    (cur[idx]),
        .tgt    (tgt[idx]),
        .step   (step),
        .enable (enable),
        .nxt    (nxt)
    );

    // In RUN, a high out_valid marks the end-of-sweep cycle where no element is processed.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        reload    = 1'b0;
        proc      = 1'b0;
        last      = 1'b0;
        pnd_load  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end else if (pend) begin
                    reload    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                pnd_load = in_valid;
                if (out_valid) begin
                    if (pend) begin
                        reload = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    proc = 1'b1;
                    last = (idx == LAST);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            pend      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= proc && last;
            if (start || reload) begin
                idx <= '0;
            end else if (proc) begin
                idx <= last ? '0 : idx + 1'b1;
            end
            // A fresh pulse always supersedes whatever was pending.
            if (pnd_load) begin
                pend <= 1'b1;
            end else if (start || reload) begin
                pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tgt[i] <= '0;
                pnd[i] <= '0;
                cur[i] <= '0;
            end
        end else begin
            if (start) begin
                tgt <= duty_m;
            end else if (reload) begin
                tgt <= pnd;
            end
            if (pnd_load) begin
                pnd <= duty_m;
            end
            if (proc) begin
                cur[idx] <= nxt;
            end
        end
    end

    assign duty_s = cur;

endmodule
